// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin front end for one shared magnitude comparator.
// One request is granted at a time. Its operands are registered and compared
// as unsigned, signed, or absolute value, depending on that requester's mode.
// A one-hot gt/eq/lt result, tagged with the requester id, is returned over a
// valid/ready response port.
module compare_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_gt,
    output logic                  rsp_eq,
    output logic                  rsp_lt,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_mode;
    int               cand;
    int               wrap;
    logic             capture;
    logic             load_rsp;
    logic             rsp_done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_mode;
    logic [IDW-1:0]   op_id;
    logic [WIDTH:0]   key_a;
    logic [WIDTH:0]   key_b;

    // Map an operand to a WIDTH+1-bit value whose unsigned order matches the
    // requested interpretation. In signed mode, flipping the sign bit of the
    // sign-extended value turns the signed order into an unsigned order.
    function automatic logic [WIDTH:0] order_key(input logic [WIDTH-1:0] x,
                                                 input logic [1:0] mode);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        case (mode)
            2'b01:   order_key = {~x[WIDTH-1], x};
            2'b10:   order_key = x[WIDTH-1] ? ((~ext) + ONE) : ext;
            default: order_key = {1'b0, x};
        endcase
    endfunction

    // Cyclic search for the first valid requester at or after ptr, and selection of its operands
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_mode    = '0;
        cand        = 0;
        wrap        = 0;
        ptr_next    = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && req_valid[IDW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
                sel_a       = req_a[cand*WIDTH +: WIDTH];
                sel_b       = req_b[cand*WIDTH +: WIDTH];
                sel_mode    = req_mode[cand*2 +: 2];
            end
        end
        wrap = int'(grant_idx) + 1;
        if (wrap >= NREQ) begin
            wrap = 0;
        end
        ptr_next = IDW'(wrap);
    end

    // State register and round-robin pointer
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                ptr <= ptr_next;
            end
        end
    end

    // Next-state logic: a grant leads to compare, then to a held response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = CMP;
            CMP:     state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state outputs: request acknowledge and datapath load strobes
    always_comb begin
        req_ready = '0;
        capture   = 1'b0;
        load_rsp  = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && rstN) begin
                    req_ready[grant_idx] = 1'b1;
                    capture              = 1'b1;
                end
            end
            CMP:     load_rsp = 1'b1;
            RESP:    rsp_done = rsp_ready;
            default: ;
        endcase
    end

    // Operand registers hold the granted request while it is being compared
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            op_a    <= '0;
            op_b    <= '0;
            op_mode <= '0;
            op_id   <= '0;
        end else if (capture) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_mode <= sel_mode;
            op_id   <= grant_idx;
        end
    end

    // Order keys of the captured operands feed a single unsigned comparator
    always_comb begin
        key_a = order_key(op_a, op_mode);
        key_b = order_key(op_b, op_mode);
    end

    // Response registers are loaded once per compare and held until the consumer accepts
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (load_rsp) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            if (op_mode == 2'b11) begin
                rsp_gt  <= 1'b0;
                rsp_eq  <= 1'b0;
                rsp_lt  <= 1'b0;
                rsp_err <= 1'b1;
            end else begin
                rsp_gt  <= (key_a > key_b);
                rsp_eq  <= (key_a == key_b);
                rsp_lt  <= (key_a < key_b);
                rsp_err <= 1'b0;
            end
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed vector table plus hand-written sequences for
// round-robin order, response backpressure and asynchronous reset.
module tb_compare_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_gt;
    logic        rsp_eq;
    logic        rsp_lt;
    logic        rsp_err;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic       gt;
        logic       eq;
        logic       lt;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    compare_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .rsp_err   (rsp_err)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Guard against a stuck design
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] mode);
        @(posedge clk);
        #1;
        req_valid = 4'(1 << id);
        req_a[id*8 +: 8]    = a;
        req_b[id*8 +: 8]    = b;
        req_mode[id*2 +: 2] = mode;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    initial begin
        int found;
        int last;

        vecs[0]  = '{0, 8'h03, 8'h05, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2, 8'hFD, 8'hFB, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2, 8'hFD, 8'hFB, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1, 8'hFD, 8'h05, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3, 8'h80, 8'h7F, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{0, 8'hFD, 8'h05, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1, 8'hFB, 8'h05, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2, 8'h01, 8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3, 8'h80, 8'h7F, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1, 8'h7F, 8'h7F, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{0, 8'h00, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3, 8'h80, 8'h80, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2, 8'h05, 8'hFD, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};

        rstN      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        rsp_ready = 1'b0;
        found     = 0;
        last      = 0;

        // Reset state, with requests pending that must not be acknowledged
        #2;
        req_valid = 4'b1111;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 0);
        checkOutput("reset_flags", 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}), 0);
        checkOutput("reset_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rstN      = 1'b1;
        rsp_ready = 1'b1;

        // Table-driven single-request vectors: grant in T, response in T+2
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].mode);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), 32'(req_ready), 1 << vecs[i].id);
            @(posedge clk);
            #1;
            req_valid = '0;
            @(negedge clk);
            checkOutput($sformatf("vec%0d_busy", i), 32'(rsp_valid), 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 1);
            checkOutput($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), vecs[i].id);
            checkOutput($sformatf("vec%0d_flags", i), 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}),
                        32'({vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].err}));
        end

        // Round-robin from reset: all requesters valid, grants 0,1,2,3,0 every 3 cycles
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #2;
        rstN     = 1'b1;
        req_a    = 32'h04030201;
        req_b    = 32'h01020304;
        req_mode = '0;
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 0;
            for (int w = 0; w < 8 && found == 0; w++) begin
                @(negedge clk);
                if (req_ready != 4'b0000) found = 1;
            end
            checkOutput($sformatf("rr%0d_found", k), found, 1);
            checkOutput($sformatf("rr%0d_order", k), 32'(req_ready), 1 << (k % 4));
            if (k > 0) checkOutput($sformatf("rr%0d_spacing", k), cyc - last, 3);
            last = cyc;
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 1);
            checkOutput($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), k % 4);
        end
        @(posedge clk);
        #1;
        req_valid = '0;

        // Backpressure: result held for 5 cycles, no grant until it is accepted
        @(posedge clk);
        #1;
        rsp_ready   = 1'b0;
        req_valid   = 4'b0010;
        req_a[15:8] = 8'd10;
        req_b[15:8] = 8'd20;
        req_mode    = '0;
        @(negedge clk);
        checkOutput("bp_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid    = 4'b0100;
        req_a[23:16] = 8'h11;
        req_b[23:16] = 8'h11;
        @(negedge clk);
        checkOutput("bp_cmp_ready", 32'(req_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 1);
            checkOutput($sformatf("bp_hold%0d_id", i), 32'(rsp_id), 1);
            checkOutput($sformatf("bp_hold%0d_flags", i), 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}), 32'h2);
            checkOutput($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_valid", 32'(rsp_valid), 1);
        checkOutput("bp_accept_ready", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("bp_next_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_second_valid", 32'(rsp_valid), 1);
        checkOutput("bp_second_id", 32'(rsp_id), 2);
        checkOutput("bp_second_flags", 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}), 32'h4);

        // Asynchronous reset during CMP clears everything and restarts priority at 0
        @(posedge clk);
        #1;
        rsp_ready     = 1'b0;
        req_valid     = 4'b0001;
        req_a[7:0]    = 8'h7F;
        req_b[7:0]    = 8'h80;
        req_mode[1:0] = 2'b01;
        req_a[15:8]   = 8'h01;
        req_b[15:8]   = 8'h02;
        @(negedge clk);
        checkOutput("rst_pre_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 4'b0011;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("rst_flags", 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}), 0);
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_priority", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_replay", 32'(rsp_valid), 0);
        @(negedge clk);
        checkOutput("rst_after_valid", 32'(rsp_valid), 1);
        checkOutput("rst_after_id", 32'(rsp_id), 0);
        checkOutput("rst_after_flags", 32'({rsp_gt, rsp_eq, rsp_lt, rsp_err}), 32'h8);
        @(posedge clk);
        #1;
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
